// File: rtl/ifetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN       : datapath width
//   NOP_INSTR  : instruction presented on out_instr while the buffer is empty
//   PC_STEP    : byte distance between consecutive fetch words
//   fetch_entry_t : one buffered {pc, instr} pair
//   align_pc() : forces a target address onto a word boundary
package riscv_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ifetch_buffer_if.sv
// Bundle of the fetch front end's handshake signals.
//   imem_req_*  : fetch request channel toward instruction memory
//   imem_resp_* : in-order response channel, no backpressure
//   redirect_*  : control-flow redirect from branch resolution
//   out_*       : buffered {pc, instr} stream toward IF/ID
// master : the fetch buffer side
// slave  : the environment side (memory, branch unit, IF/ID)
interface ifetch_buffer_if;
    import riscv_fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/ifetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : empties the FIFO; wins over push and pop
//   push_i       : write push_data_i at the tail (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : head entry, combinational
//   count_o      : number of stored entries, 0..DEPTH
//   empty_o/full_o : occupancy flags
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is only consumed when count says so.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: issues word fetches, buffers in-order
// responses as {pc, instr} and hands them to IF/ID; a redirect flushes
// the buffer, squashes outstanding fetches and restarts at the target.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ifetch_buffer_if.master (request, response, redirect, output)
module ifetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    ifetch_buffer_if.master   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             req_fire, resp_keep, pop;
    logic             fifo_empty, fifo_full;
    fetch_entry_t     head, push_entry;

    // inflight counts every outstanding request, squashed ones included,
    // so credit also covers responses that will be dropped and drop_cnt
    // can never exceed inflight (hence never exceeds DEPTH).
    assign occupancy          = {1'b0, count} + {1'b0, inflight_q};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid
                                && (occupancy < (CNT_W+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_keep  = bus.imem_resp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
    assign pop        = bus.out_valid && bus.out_ready;
    assign push_entry = '{pc: resp_pc_q, instr: bus.imem_resp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redirect_valid),
        .push_i      (resp_keep),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_pc    = fifo_empty ? '0 : head.pc;
    assign bus.out_instr = fifo_empty ? NOP_INSTR : head.instr;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;

        case ({req_fire, bus.imem_resp_valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (bus.redirect_valid) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
            resp_pc_d  = align_pc(bus.redirect_pc);
            // Everything still outstanding after this cycle belongs to the
            // old path; a response arriving now is already excluded.
            drop_cnt_d = inflight_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (bus.imem_resp_valid) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
                else                  resp_pc_d  = resp_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Credit must keep room for every response that is kept.
    always_ff @(posedge clk) begin
        if (!rst && resp_keep) assert (!fifo_full);
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;
    import riscv_fetch_pkg::*;

    localparam int              DEPTH    = 4;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic rst;
    ifetch_buffer_if bus ();

    ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding memory requests tagged with the path
    // epoch they were fetched on, and the queue of entries IF/ID should see.
    req_t        pend_q[$];
    ent_t        buf_q[$];
    logic [31:0] m_fetch_pc;
    int unsigned epoch;
    int unsigned cyc;
    int unsigned lat_lo, lat_hi;
    int          vecs, fails;
    int          issued;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle(input bit ordy, input bit redir, input logic [31:0] rpc,
                         input bit mrdy, input bit do_rst);
        bit          exp_req, resp, kept;
        req_t        r;
        int unsigned lat;

        rst                = do_rst;
        bus.out_ready      = ordy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = mrdy;
        resp = !do_rst && (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        bus.imem_resp_valid = resp;
        bus.imem_resp_data  = resp ? instr_of(pend_q[0].addr) : 32'($urandom);
        #1;
        exp_req = !do_rst && !redir && (buf_q.size() + pend_q.size() < DEPTH);
        if (bus.imem_req_valid && mrdy) issued++;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", bus.imem_req_addr, m_fetch_pc);
        if (!do_rst) begin
            chk("out_valid", 32'(bus.out_valid), 32'(buf_q.size() != 0));
            if (buf_q.size() != 0) begin
                chk("out_pc", bus.out_pc, buf_q[0].pc);
                chk("out_instr", bus.out_instr, buf_q[0].instr);
            end else begin
                chk("idle_pc", bus.out_pc, 32'h0);
                chk("idle_instr", bus.out_instr, NOP_INSTR);
            end
        end
        @(posedge clk);
        if (do_rst) begin
            pend_q.delete();
            buf_q.delete();
            m_fetch_pc = RESET_PC;
            epoch++;
        end else begin
            kept = 1'b0;
            if (resp) begin
                r    = pend_q.pop_front();
                kept = (r.epoch == epoch) && !redir;
            end
            if (redir) begin
                buf_q.delete();
                epoch++;
                m_fetch_pc = rpc & ~32'h3;
            end else begin
                if (ordy && buf_q.size() != 0) void'(buf_q.pop_front());
                if (kept) buf_q.push_back('{r.addr, instr_of(r.addr)});
                if (exp_req && mrdy) begin
                    lat = $urandom_range(lat_hi, lat_lo);
                    pend_q.push_back('{m_fetch_pc, epoch, cyc + lat});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(ordy, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        clk = 1'b0;
        rst = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.out_ready       = 1'b0;
        vecs = 0; fails = 0; cyc = 0; epoch = 0; issued = 0;
        m_fetch_pc = RESET_PC;
        lat_lo = 1; lat_hi = 1;

        // Reset, then 1-cycle memory with IF/ID always ready.
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        run(20, 1'b1);

        // IF/ID stalled for 10 cycles after a fresh reset: exactly DEPTH fetches.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        issued = 0;
        run(10, 1'b0);
        chk("issued_while_stalled", 32'(issued), 32'(DEPTH));
        run(12, 1'b1);

        // 3-cycle memory, redirect with fetches in flight, then back-to-back redirects.
        lat_lo = 3; lat_hi = 3;
        run(12, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        run(15, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b0);
        run(15, 1'b1);

        // Redirect to an unaligned target while a response and a pop coincide.
        lat_lo = 1; lat_hi = 1;
        run(8, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0203, 1'b1, 1'b0);
        run(8, 1'b1);

        // Address wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        run(10, 1'b1);

        // Reset while three entries are buffered.
        cycle(1'b0, 1'b1, 32'h0000_0800, 1'b1, 1'b0);
        n = 0;
        while (buf_q.size() != 3 && n < 20) begin
            cycle(1'b0, 1'b0, 32'h0, (buf_q.size() + pend_q.size()) < 3, 1'b0);
            n++;
        end
        chk("three_buffered_reached", 32'(n < 20), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        run(10, 1'b1);

        // Randomized traffic: variable latency, stalls, redirects, resets.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 600; i++) begin
            bit          rd, rs;
            logic [31:0] tgt;
            rd  = ($urandom_range(19, 0) == 0);
            rs  = ($urandom_range(149, 0) == 0);
            tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : 32'($urandom);
            cycle($urandom_range(9, 0) < 7, rd, tgt, $urandom_range(3, 0) != 0, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
